// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// one transaction at a time, LSU priority with a fetch-starvation streak limit and a hang timeout.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_gnt,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_mask,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = MAX_LSU_STREAK > 0 ? $clog2(MAX_LSU_STREAK + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] streak;
  logic lsu_win, tmo, done, accept, enter_resp;
  logic [DATA_W-1:0] resp_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Completion beats the timeout when both land on the same edge.
  always_comb begin
    lsu_win = lsu_req && !(ifu_req && streak == SW'(MAX_LSU_STREAK));
    accept = state == IDLE && (ifu_req || lsu_req);
    tmo = TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1);
    done = (state == REQ && mem_gnt && mem_rvalid) || (state == WAIT && mem_rvalid);
    state_n = state;
    case (state)
      IDLE: state_n = accept ? REQ : IDLE;
      REQ:  state_n = (done || tmo) ? RESP : mem_gnt ? WAIT : REQ;
      WAIT: state_n = (done || tmo) ? RESP : WAIT;
      RESP: state_n = IDLE;
    endcase
    enter_resp = (state == REQ || state == WAIT) && state_n == RESP;
    resp_data = (done && !mem_we) ? mem_rdata : '0;
  end
  always_comb begin
    busy = state != IDLE;
    mem_req = state == REQ;
    ifu_rvalid = state == RESP && !owner;
    lsu_rvalid = state == RESP && owner;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner <= 1'b0;
      ifu_gnt <= 1'b0;
      lsu_gnt <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_mask <= '0;
      streak <= '0;
      tcnt <= '0;
      ifu_rdata <= '0;
      ifu_err <= 1'b0;
      lsu_rdata <= '0;
      lsu_err <= 1'b0;
    end else begin
      ifu_gnt <= accept && !lsu_win;
      lsu_gnt <= accept && lsu_win;
      tcnt <= (state == REQ || state == WAIT) ? tcnt + 1'b1 : '0;
      if (accept) begin
        owner <= lsu_win;
        mem_we <= lsu_win && lsu_we;
        mem_addr <= lsu_win ? lsu_addr : ifu_addr;
        mem_wdata <= lsu_win ? lsu_wdata : '0;
        mem_mask <= lsu_win ? lsu_mask : '1;
        streak <= (lsu_win && ifu_req) ? streak + 1'b1 : '0;
      end
      if (enter_resp && owner) begin
        lsu_rdata <= resp_data;
        lsu_err <= !done;
      end
      if (enter_resp && !owner) begin
        ifu_rdata <= resp_data;
        ifu_err <= !done;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, timeout and async reset.
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic ifu_req = 0, lsu_req = 0, lsu_we = 0, mem_gnt = 1, mem_rvalid = 0;
  logic [31:0] ifu_addr = 0, lsu_addr = 0, lsu_wdata = 0, mem_rdata = 0;
  logic [3:0] lsu_mask = 0;
  logic ifu_gnt, ifu_rvalid, ifu_err, lsu_gnt, lsu_rvalid, lsu_err;
  logic mem_req, mem_we, busy, owner;
  logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_mask;
  int tests = 0, fails = 0;
  logic who;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .MAX_LSU_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_mask(lsu_mask), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // One arbitrated transaction starting in an IDLE cycle; reports the winner.
  task automatic txn(output logic w);
    tick();
    chk("txn_one_gnt", {62'd0, ifu_gnt, lsu_gnt}, lsu_gnt ? 64'd1 : 64'd2);
    w = lsu_gnt;
    tick();
    mem_rvalid = 1;
    tick();
    mem_rvalid = 0;
    chk("txn_rvalid", {62'd0, ifu_rvalid, lsu_rvalid}, w ? 64'd1 : 64'd2);
    tick();
  endtask
  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_gnts", {ifu_gnt, lsu_gnt}, 0);
    chk("rst_rvalids", {ifu_rvalid, lsu_rvalid}, 0);
    chk("rst_owner", owner, 0);
    tick();
    rst = 0;
    tick();
    // single IFU fetch, minimum latency
    ifu_req = 1; ifu_addr = 32'h8000_0000;
    tick();
    ifu_req = 0;
    chk("f_gnt", {ifu_gnt, lsu_gnt}, 2'b10);
    chk("f_mem_req", mem_req, 1);
    chk("f_addr", mem_addr, 32'h8000_0000);
    chk("f_we", mem_we, 0);
    chk("f_mask", mem_mask, 4'hF);
    chk("f_wdata", mem_wdata, 0);
    chk("f_busy_owner", {busy, owner}, 2'b10);
    tick();
    chk("f_wait", {mem_req, ifu_gnt}, 0);
    mem_rvalid = 1; mem_rdata = 32'h0010_0093;
    tick();
    mem_rvalid = 0;
    chk("f_rvalid", {ifu_rvalid, lsu_rvalid}, 2'b10);
    chk("f_rdata", ifu_rdata, 32'h0010_0093);
    chk("f_err", ifu_err, 0);
    tick();
    chk("f_idle", {busy, ifu_rvalid}, 0);
    chk("f_hold", ifu_rdata, 32'h0010_0093);
    // LSU store: read data forced to zero
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_mask = 4'h3;
    tick();
    lsu_req = 0; lsu_we = 0; lsu_wdata = 0;
    chk("s_gnt", {ifu_gnt, lsu_gnt}, 2'b01);
    chk("s_fields", {mem_req, mem_we, mem_mask, mem_addr}, {1'b1, 1'b1, 4'h3, 32'h8000_1000});
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_owner", owner, 1);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 0;
    chk("s_rvalid", {ifu_rvalid, lsu_rvalid}, 2'b01);
    chk("s_rdata", lsu_rdata, 0);
    chk("s_err", lsu_err, 0);
    tick();
    // LSU load answered in the grant cycle goes straight to RESP
    lsu_req = 1; lsu_addr = 32'h8000_2000; lsu_mask = 4'hF;
    tick();
    lsu_req = 0;
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 0;
    chk("l_fast_rvalid", lsu_rvalid, 1);
    chk("l_fast_rdata", lsu_rdata, 32'hCAFE_F00D);
    tick();
    // contention with both held high
    ifu_req = 1; lsu_req = 1; lsu_addr = 32'h8000_3000;
    for (int i = 0; i < 10; i++) begin
      txn(who);
      chk($sformatf("cont_%0d", i), who, (i % 5 == 4) ? 1'b0 : 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      txn(who);
      chk($sformatf("pre_%0d", i), who, 1);
    end
    ifu_req = 0;
    txn(who);
    chk("uncontested", who, 1);
    ifu_req = 1;
    for (int i = 0; i < 5; i++) begin
      txn(who);
      chk($sformatf("post_%0d", i), who, (i == 4) ? 1'b0 : 1'b1);
    end
    ifu_req = 0; lsu_req = 0;
    tick();
    // timeout with mem_gnt stuck low
    mem_gnt = 0; lsu_req = 1; lsu_addr = 32'h8000_4000;
    tick();
    lsu_req = 0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("to_hold_%0d", i), {lsu_rvalid, mem_req}, 2'b01);
    end
    tick();
    chk("to_rvalid", lsu_rvalid, 1);
    chk("to_err", lsu_err, 1);
    chk("to_rdata", lsu_rdata, 0);
    chk("to_mem_req", mem_req, 0);
    tick();
    mem_gnt = 1; ifu_req = 1; ifu_addr = 32'h8000_0004;
    tick();
    ifu_req = 0;
    chk("after_to_gnt", ifu_gnt, 1);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    tick();
    mem_rvalid = 0;
    chk("after_to_resp", {ifu_rvalid, ifu_err, ifu_rdata}, {1'b1, 1'b0, 32'h0000_0013});
    tick();
    // stalled grant
    mem_gnt = 0; ifu_req = 1; ifu_addr = 32'h8000_0040;
    tick();
    ifu_req = 0; ifu_addr = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_%0d", i), {mem_req, mem_we, mem_mask, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h8000_0040});
      tick();
    end
    mem_gnt = 1;
    chk("stall_still_req", mem_req, 1);
    tick();
    chk("stall_wait", mem_req, 0);
    mem_rvalid = 1; mem_rdata = 32'hA5A5_0F0F;
    tick();
    mem_rvalid = 0;
    chk("stall_resp", {ifu_rvalid, ifu_rdata}, {1'b1, 32'hA5A5_0F0F});
    tick();
    // asynchronous reset in WAIT
    lsu_req = 1; lsu_addr = 32'h8000_5000;
    tick();
    lsu_req = 0;
    tick();
    chk("r_busy", {busy, owner}, 2'b11);
    #2 rst = 1;
    #1;
    chk("r_async", {busy, mem_req, owner, lsu_gnt, lsu_rvalid, mem_we}, 0);
    chk("r_data", {lsu_rdata, mem_addr}, 0);
    #1 rst = 0;
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("r_late1", {busy, ifu_rvalid, lsu_rvalid}, 0);
    tick();
    mem_rvalid = 0;
    chk("r_late2", {busy, ifu_rvalid, lsu_rvalid, lsu_rdata}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
